display_scan_controller: RTL and testbench
==========================================

# display_scan_controller

Sequencing controller for the 4-digit multiplexed seven-segment display. It accepts a binary value (0–9999) through a ready/valid load handshake and converts it to BCD with a sequential double-dabble converter. It then time-multiplexes the four digits onto the shared digit-select / BCD bus that feeds the seven-segment decoder, with anti-ghosting guard blanking and optional leading-zero suppression. It sits between the button/value source and the decoder, driven by the oscillator clock plus a scan strobe from the clock divider.

## Interface
- GUARD_CYCLES, default 2: clocks of all-off digit enables after every digit change (anti-ghost); legal range 0–15.
- clk_i  in  1  system clock (oscillator domain)
- reset  in  1  asynchronous, active-high reset
- tick_i  in  1  scan strobe, one clk_i cycle wide; advances the digit
- value_i  in  14  binary value to display
- load_i  in  1  load request; value_i qualified by it
- ready_o  out  1  high when a load will be accepted
- blank_lz_i  in  1  1 = suppress leading zeros
- digit_sel_o  out  2  index of digit currently driven (0 = ones, 3 = thousands)
- digit_en_o  out  4  one-hot active-high digit enable; all-zero when blanked
- bcd_o  out  4  BCD of the selected digit; 4'hF when blanked
- over_o  out  1  displayed value was clamped

## Operation
- Load handshake: transfer occurs on the edge where load_i && ready_o. load_i while ready_o=0 is ignored (not queued).
- Clamp on accept: if value_i > 9999, load 9999 and record over=1; else over=0.
- Converter FSM states:
  - IDLE: ready_o=1.
  - CONV: ready_o=0; each clock does one double-dabble iteration (add-3 to each nibble ≥5, then shift left 1). 14 iterations.
  - Transition: on the 14th iteration edge, write the result into the display register, latch over into over_o, and return to IDLE.
- Display register only changes atomically; digits never show partial conversions.
- Scan: digit_sel is a 2-bit counter, 3→0 wrap. It increments on each edge with tick_i=1.
  - On increment, the guard counter is loaded with GUARD_CYCLES and decrements each clock to 0.
  - digit_en_o is all-zero while guard≠0.
  - A tick during guard still advances the digit and restarts the guard.
- Blanking: digit k (k≥1) is blank when blank_lz_i=1 and display digits 3..k are all zero. Digit 0 is never blanked (value 0 shows "0").
- Output: when digit k is not blank and guard=0, digit_en_o = 1<<k and bcd_o = digit k. When k is blank, digit_en_o=0 and bcd_o=4'hF.
- Outputs are combinational from registered state (digit_sel, guard, display register, blank_lz_i).

## Timing
- Reset values: digit_sel_o=0, guard=GUARD_CYCLES, display register=0, digit_en_o=0, bcd_o=0, ready_o=1, over_o=0, FSM=IDLE.
- Load latency:
  - Accept at edge N; ready_o low from after N.
  - New digits are visible after edge N+14; ready_o is high again after N+14.
  - Back-to-back loads: next accept is possible at edge N+15.
- Reset during CONV aborts the conversion. Display returns to 0 and the pending value is lost.
- A display update coincident with a tick: the new digit index and new contents both take effect after the same edge.
- GUARD_CYCLES=0: enable is valid in the cycle right after the tick edge.
- blank_lz_i changes take effect combinationally, with no latency.

## Structure
- Package display_pkg:
  - NUM_DIGITS=4, MAX_VALUE=14'd9999, BCD_BLANK=4'hF, CONV_ITERS=14.
  - conv_state_t enum {IDLE, CONV}.
- Sub-module bin2bcd_seq: start/value in, busy/done/bcd[15:0] out. Holds the shift register and iteration counter.
- Top: clamp, handshake, display register, scan counter, guard counter, blank logic.

## Test plan
- Reset then tick×4, GUARD=2, no load: digit_sel cycles 0,1,2,3,0. digit_en_o=0 for 2 clocks after each tick, then 0001/0010/0100/1000. bcd_o=0 throughout.
- Load 1234: ready_o low exactly 14 cycles. Display then scans bcd 4,3,2,1 for digits 0..3. over_o=0.
- Load 14'd12000: displays 9999, over_o=1. Next load of 5 clears over_o.
- Load 7 with blank_lz_i=1: digit 0 shows 7. Digits 1–3 have digit_en_o=0 and bcd_o=F. Load 1007: no digits blanked.
- Pulse load_i with 42 during CONV of 1234: ignored, display 1234. Assert reset at iteration 7 of a new conversion: display 0, ready_o=1 immediately.
- Tick on the edge the conversion completes: new digit index shows the new value. Tick during guard restarts the guard.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants, types and the double-dabble step for the display scan controller.
// The converter and the top-level controller both import this package.
package display_pkg;

  localparam int          NUM_DIGITS = 4;
  localparam logic [13:0] MAX_VALUE  = 14'd9999;
  localparam logic [3:0]  BCD_BLANK  = 4'hF;
  localparam int          CONV_ITERS = 14;
  localparam int          SR_W       = 4 * NUM_DIGITS + CONV_ITERS;

  typedef enum logic {
    IDLE,
    CONV
  } conv_state_t;

  // One double-dabble iteration over {bcd[15:0], bin[13:0]}: add 3 to every
  // BCD nibble >= 5, then shift the whole register left by one.
  function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
    logic [SR_W-1:0] adj;
    adj = sr;
    for (int n = 0; n < NUM_DIGITS; n++) begin
      if (adj[CONV_ITERS + 4*n +: 4] >= 4'd5)
        adj[CONV_ITERS + 4*n +: 4] = adj[CONV_ITERS + 4*n +: 4] + 4'd3;
    end
    return {adj[SR_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/display_scan_controller_if.sv
// Load handshake and digit bus of the display scan controller.
// master drives the value/strobe side; slave is the controller itself.
interface display_scan_controller_if;
  logic        tick_i;
  logic [13:0] value_i;
  logic        load_i;
  logic        ready_o;
  logic        blank_lz_i;
  logic [1:0]  digit_sel_o;
  logic [3:0]  digit_en_o;
  logic [3:0]  bcd_o;
  logic        over_o;

  modport master (
    output tick_i, value_i, load_i, blank_lz_i,
    input  ready_o, digit_sel_o, digit_en_o, bcd_o, over_o
  );

  modport slave (
    input  tick_i, value_i, load_i, blank_lz_i,
    output ready_o, digit_sel_o, digit_en_o, bcd_o, over_o
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter, one double-dabble iteration per clock.
// done and bcd describe the iteration completing on the current edge.
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] value,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd
);

  logic [SR_W-1:0] sr;
  logic [SR_W-1:0] next_sr;
  logic [3:0]      iter;
  logic            busy_q;

  assign next_sr = dabble_step(sr);
  assign busy    = busy_q;
  assign done    = busy_q && (iter == 4'(CONV_ITERS - 1));
  assign bcd     = next_sr[SR_W-1 -: 16];

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      sr     <= '0;
      iter   <= '0;
      busy_q <= 1'b0;
    end else if (start && !busy_q) begin
      sr     <= {16'b0, value};
      iter   <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      sr   <= next_sr;
      iter <= iter + 4'd1;
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/display_scan_controller.sv
// 4-digit multiplexed seven-segment scan controller: clamped load handshake, BCD
// conversion, digit scan with anti-ghost guard blanking and leading-zero suppression.
module display_scan_controller
  import display_pkg::*;
#(
  parameter int GUARD_CYCLES = 2
) (
  input  logic                       clk_i,
  input  logic                       reset,
  display_scan_controller_if.slave   bus
);

  localparam logic [3:0] GUARD_INIT = 4'(GUARD_CYCLES);

  conv_state_t state;
  logic        ready_q;
  logic        over_q;
  logic        pend_over;
  logic [15:0] disp;
  logic [1:0]  sel;
  logic [3:0]  guard;

  logic        value_over;
  logic [13:0] clamped;
  logic        accept;
  logic        conv_busy;
  logic        conv_done;
  logic [15:0] conv_bcd;

  assign value_over = bus.value_i > MAX_VALUE;
  assign clamped    = value_over ? MAX_VALUE : bus.value_i;
  assign accept     = bus.load_i && ready_q && !conv_busy;

  bin2bcd_seq u_conv (
    .clk_i (clk_i),
    .reset (reset),
    .start (accept),
    .value (clamped),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // The display register is only written with a finished conversion, so the
  // scan never sees a partial result.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ready_q   <= 1'b1;
      over_q    <= 1'b0;
      pend_over <= 1'b0;
      disp      <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          pend_over <= value_over;
          ready_q   <= 1'b0;
          state     <= CONV;
        end
        CONV: if (conv_done) begin
          disp    <= conv_bcd;
          over_q  <= pend_over;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A tick always advances the digit and restarts the guard, even mid-guard.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      sel   <= '0;
      guard <= GUARD_INIT;
    end else if (bus.tick_i) begin
      sel   <= sel + 2'd1;
      guard <= GUARD_INIT;
    end else if (guard != 4'd0) begin
      guard <= guard - 4'd1;
    end
  end

  logic [3:0] blank_vec;
  logic [3:0] cur_digit;
  logic       cur_blank;

  // Digit k (k >= 1) is blank when it and every digit above it is zero.
  assign blank_vec = {bus.blank_lz_i && (disp[15:12] == 4'd0),
                      bus.blank_lz_i && (disp[15:8]  == 8'd0),
                      bus.blank_lz_i && (disp[15:4]  == 12'd0),
                      1'b0};
  assign cur_digit = disp[{sel, 2'b00} +: 4];
  assign cur_blank = blank_vec[sel];

  assign bus.ready_o     = ready_q;
  assign bus.over_o      = over_q;
  assign bus.digit_sel_o = sel;
  assign bus.bcd_o       = cur_blank ? BCD_BLANK : cur_digit;
  assign bus.digit_en_o  = (!cur_blank && guard == 4'd0) ? (4'b0001 << sel) : 4'b0000;

endmodule

// File: tb/tb_display_scan_controller.sv
// Self-checking bench for display_scan_controller: directed scenarios followed by
// randomized load/tick/blank/reset traffic, compared against a value-level model.
module tb_display_scan_controller;

  localparam int GUARD = 2;

  logic clk;
  logic reset;

  display_scan_controller_if bus ();

  display_scan_controller #(.GUARD_CYCLES(GUARD)) dut (
    .clk_i (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: displayed value as an integer, conversion as a countdown of clocks,
  // scan position as tick count modulo 4, guard as clocks since the last tick.
  int m_disp, m_over, m_busy_left, m_pend_val, m_pend_over, m_sel, m_since_tick;
  bit cur_blz;
  int pow10 [4] = '{1, 10, 100, 1000};

  task automatic model_reset();
    m_disp       = 0;
    m_over       = 0;
    m_busy_left  = 0;
    m_pend_val   = 0;
    m_pend_over  = 0;
    m_sel        = 0;
    m_since_tick = 0;
  endtask

  task automatic model_edge(input bit ld, input bit tk, input int v);
    if (m_busy_left > 0) begin
      m_busy_left--;
      if (m_busy_left == 0) begin
        m_disp = m_pend_val;
        m_over = m_pend_over;
      end
    end else if (ld) begin
      m_pend_val  = (v > 9999) ? 9999 : v;
      m_pend_over = (v > 9999) ? 1 : 0;
      m_busy_left = 14;
    end
    if (tk) begin
      m_sel        = (m_sel + 1) % 4;
      m_since_tick = 0;
    end else if (m_since_tick < 1000) begin
      m_since_tick++;
    end
  endtask

  task automatic check_outputs();
    int  k;
    bit  blank;
    int  exp_en, exp_bcd;
    k      = m_sel;
    blank  = (k >= 1) && cur_blz && (m_disp < pow10[k]);
    exp_bcd = blank ? 15 : (m_disp / pow10[k]) % 10;
    exp_en  = (!blank && m_since_tick >= GUARD) ? (1 << k) : 0;
    check("ready", bus.ready_o, (m_busy_left == 0) ? 1 : 0);
    check("digit_sel", bus.digit_sel_o, k);
    check("digit_en", bus.digit_en_o, exp_en);
    check("bcd", bus.bcd_o, exp_bcd);
    check("over", bus.over_o, m_over);
  endtask

  task automatic cycle(input bit ld, input bit tk, input int v, input bit blz);
    bus.load_i     = ld;
    bus.tick_i     = tk;
    bus.value_i    = v[13:0];
    bus.blank_lz_i = blz;
    cur_blz        = blz;
    @(posedge clk);
    model_edge(ld, tk, v);
    #1;
    check_outputs();
  endtask

  // Idle cycles with a tick every `every` cycles (0 = no ticks).
  task automatic run(input int n, input int every, input bit blz);
    for (int i = 0; i < n; i++)
      cycle(1'b0, (every != 0) && (i % every == every - 1), 0, blz);
  endtask

  // Asynchronous reset in the middle of a clock period.
  task automatic do_reset();
    bus.load_i = 1'b0;
    bus.tick_i = 1'b0;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    bus.load_i     = 1'b0;
    bus.tick_i     = 1'b0;
    bus.value_i    = '0;
    bus.blank_lz_i = 1'b0;
    cur_blz        = 1'b0;
    model_reset();
    @(negedge clk);
    check_outputs();
    reset = 1'b0;

    // Scan with no load: guard blanking after each tick, bcd stays 0.
    for (int t = 0; t < 5; t++) begin
      cycle(1'b0, 1'b1, 0, 1'b0);
      run(3, 0, 1'b0);
    end

    // Load 1234 and scan it.
    cycle(1'b1, 1'b0, 1234, 1'b0);
    run(20, 4, 1'b0);

    // Clamp to 9999, then a normal load clears over.
    cycle(1'b1, 1'b0, 12000, 1'b0);
    run(20, 4, 1'b0);
    cycle(1'b1, 1'b0, 5, 1'b0);
    run(20, 4, 1'b0);

    // Leading-zero suppression.
    cycle(1'b1, 1'b0, 7, 1'b1);
    run(20, 4, 1'b1);
    cycle(1'b1, 1'b0, 1007, 1'b1);
    run(20, 4, 1'b1);
    run(8, 4, 1'b0);

    // Load during conversion is ignored.
    cycle(1'b1, 1'b0, 1234, 1'b0);
    run(3, 0, 1'b0);
    cycle(1'b1, 1'b0, 42, 1'b0);
    run(16, 4, 1'b0);

    // Reset part-way through a conversion.
    cycle(1'b1, 1'b0, 5555, 1'b0);
    run(7, 0, 1'b0);
    do_reset();
    run(8, 4, 1'b0);

    // Tick on the completing edge, then ticks during guard.
    cycle(1'b1, 1'b0, 9876, 1'b0);
    run(13, 0, 1'b0);
    cycle(1'b0, 1'b1, 0, 1'b0);
    cycle(1'b0, 1'b1, 0, 1'b0);
    run(1, 0, 1'b0);
    cycle(1'b0, 1'b1, 0, 1'b0);
    run(4, 0, 1'b0);

    // Back-to-back loads: the edge right after completion accepts.
    cycle(1'b1, 1'b0, 321, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 4321, 1'b0);
    run(16, 4, 1'b0);

    // Randomized traffic.
    begin
      bit blz;
      blz = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        int v;
        int sel_r;
        sel_r = $urandom_range(0, 9);
        if (sel_r < 4)      v = $urandom_range(0, 20);
        else if (sel_r < 8) v = $urandom_range(0, 9999);
        else                v = $urandom_range(10000, 16383);
        if ($urandom_range(0, 49) == 0) blz = ~blz;
        cycle($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, v, blz);
        if ($urandom_range(0, 299) == 0) do_reset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
